// File: rtl/if_id_fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, reset defaults,
// instruction field positions and the opcode values control decodes.
package if_id_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

endpackage

// File: rtl/if_id_fetch_if.sv
// Fetch-stage bus: instruction-memory handshake on one side, the IF/ID
// register, hazard stall and ID redirect on the other.
interface if_id_fetch_if #(
    parameter int ADDR_W = 30
);
    // instruction memory side
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_stall;

    // decode / control side
    logic              id_stall;
    logic              redirect_valid;
    logic [31:0]       redirect_target;
    logic [31:0]       id_instr;
    logic [31:0]       id_pc_plus4;
    logic              id_valid;
    logic [5:0]        Opcode;
    logic [5:0]        func;
    logic              fetch_busy;

    // fetch unit drives requests and the IF/ID register
    modport master (
        output imem_req, imem_addr, id_instr, id_pc_plus4, id_valid,
               Opcode, func, fetch_busy,
        input  imem_rdata, imem_stall, id_stall, redirect_valid, redirect_target
    );

    // memory model / decode stage see the mirror image
    modport slave (
        input  imem_req, imem_addr, id_instr, id_pc_plus4, id_valid,
               Opcode, func, fetch_busy,
        output imem_rdata, imem_stall, id_stall, redirect_valid, redirect_target
    );

endinterface

// File: rtl/if_id_fetch_skid_buf.sv
// One-entry skid register catching a fetched word while decode is stalled.
module if_id_fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic        i_pop,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc_plus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc_plus4,
    output logic        o_full
);

    logic        r_full;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;

    // Occupancy flag: clear/pop win over load so a squash never leaves stale data.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) begin
            r_full <= 1'b0;
        end else if (i_clear || i_pop) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end
    end

    // Payload capture; qualified by r_full, so it needs no reset.
    always_ff @(posedge clk) begin
        // NOTE: data-path storage is deliberately left unreset; only the valid flag must be known.
        if (i_load && !i_clear) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_full     = r_full;

endmodule

// File: rtl/if_id_fetch.sv
// Instruction fetch stage plus IF/ID pipeline register. Holds the PC,
// issues stall-tolerant word requests, buffers a word while decode is
// frozen and squashes the wrong path on an ID-resolved redirect.
module if_id_fetch
    import if_id_fetch_pkg::*;
#(
    parameter int          ADDR_W   = 30,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input logic           clk,
    input logic           rst,
    if_id_fetch_if.master bus
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_target;
    logic         r_imem_req;
    logic [31:0]  r_id_instr;
    logic [31:0]  r_id_pc_plus4;
    logic         r_id_valid;

    logic         w_resp;
    logic         w_pending;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_skid_load;
    logic         w_skid_pop;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc_plus4;
    logic         w_skid_full;

    // A word returns when a request is up and memory is not stalling.
    assign w_resp     = r_imem_req & ~bus.imem_stall;
    assign w_pending  = r_imem_req &  bus.imem_stall;
    // Redirects are ignored during the single boot cycle.
    assign w_redirect = bus.redirect_valid & (r_state != ST_BOOT);
    assign w_target   = bus.redirect_target & 32'hFFFF_FFFC;
    assign w_pc_plus4 = r_pc + 32'd4;

    assign w_skid_load = (r_state == ST_FETCH) & w_resp & bus.id_stall & ~w_redirect;
    assign w_skid_pop  = (r_state == ST_HOLD) & ~bus.id_stall & ~w_redirect;

    if_id_fetch_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_skid_load),
        .i_clear    (w_redirect),
        .i_pop      (w_skid_pop),
        .i_instr    (bus.imem_rdata),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (w_skid_instr),
        .o_pc_plus4 (w_skid_pc_plus4),
        .o_full     (w_skid_full)
    );

    // Fetch FSM with PC, redirect target, request and IF/ID as registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= PC_RESET;
            r_target      <= PC_RESET;
            r_imem_req    <= 1'b0;
            r_id_instr    <= NOP_WORD;
            r_id_pc_plus4 <= 32'd0;
            r_id_valid    <= 1'b0;
        end else if (w_redirect) begin
            // Squash whatever sits in IF/ID, even under a decode stall.
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
            r_imem_req <= 1'b1;
            if (w_pending) begin
                // Outstanding request must complete on its old address first.
                r_target <= w_target;
                r_state  <= ST_DRAIN;
            end else begin
                r_pc    <= w_target;
                r_state <= ST_FETCH;
            end
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (w_resp) begin
                        r_pc <= w_pc_plus4;
                        if (bus.id_stall) begin
                            r_state    <= ST_HOLD;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_id_instr    <= bus.imem_rdata;
                            r_id_pc_plus4 <= w_pc_plus4;
                            r_id_valid    <= 1'b1;
                        end
                    end else if (!bus.id_stall) begin
                        r_id_instr <= NOP_WORD;
                        r_id_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!bus.id_stall) begin
                        r_id_instr    <= w_skid_instr;
                        r_id_pc_plus4 <= w_skid_pc_plus4;
                        r_id_valid    <= w_skid_full;
                        r_state       <= ST_FETCH;
                        r_imem_req    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Stale word is dropped; IF/ID already holds the squash bubble.
                    if (w_resp) begin
                        r_pc    <= r_target;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc[ADDR_W+1:2];
    assign bus.id_instr    = r_id_instr;
    assign bus.id_pc_plus4 = r_id_pc_plus4;
    assign bus.id_valid    = r_id_valid;
    assign bus.Opcode      = r_id_instr[OPCODE_MSB:OPCODE_LSB];
    assign bus.func        = r_id_instr[FUNC_MSB:FUNC_LSB];
    assign bus.fetch_busy  = (r_state == ST_DRAIN) | w_pending;

endmodule

// File: doc/if_id_fetch.md
Name: if_id_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control unit.
- Maintains the PC and issues word requests to the instruction memory/cache with a stall handshake.
- Buffers a returned instruction while decode is stalled.
- Presents a registered instruction, PC+4, a valid bit and the Opcode/func fields to the control block.
- Accepts branch/jump/JR redirects resolved in ID, squashing the wrong-path instruction.

Parameters:
- ADDR_W, 30: instruction memory word-address width; imem_addr = pc[ADDR_W+1:2].
- PC_RESET, 32'h0000_0000: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: instruction word driven into IF/ID on bubble or flush.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request; address held stable while high.
- imem_addr  output  ADDR_W  word address of the fetch.
- imem_rdata  input  32  instruction data; valid in the cycle imem_req=1 and imem_stall=0.
- imem_stall  input  1  memory not ready; the request must be held.
- id_stall  input  1  hazard unit freezes IF/ID; contents are held.
- redirect_valid  input  1  taken branch, J, JAL or JR from ID.
- redirect_target  input  32  new PC; bits [1:0] are ignored and forced to 0.
- id_instr  output  32  registered instruction.
- id_pc_plus4  output  32  registered PC+4 of id_instr; used for JAL link and branch base.
- id_valid  output  1  id_instr is a real instruction.
- Opcode  output  6  id_instr[31:26]; feeds control.
- func  output  6  id_instr[5:0]; feeds control.
- fetch_busy  output  1  high while state is DRAIN or a request is pending with imem_stall=1.

Behaviour:
- Reset values (asynchronous): pc=PC_RESET, state=BOOT, imem_req=0, id_instr=NOP_WORD, id_pc_plus4=0, id_valid=0, skid buffer empty.
- BOOT: imem_req=0 for exactly one cycle, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc word address.
  - Response (imem_stall=0), id_stall=0, no redirect: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4. Back-to-back fetches give 1 instruction per cycle.
  - Response with id_stall=1: rdata and pc+4 go into the skid buffer; pc <= pc+4; go to HOLD.
  - No response (imem_stall=1): IF/ID gets a bubble (valid=0, NOP_WORD) unless id_stall=1, in which case IF/ID holds.
- HOLD:
  - imem_req=0; IF/ID holds.
  - When id_stall drops: IF/ID <= skid contents, valid=1; skid cleared; go to FETCH the next cycle.
- Redirect (highest priority, any state except BOOT):
  - IF/ID <= NOP_WORD with valid=0, even if id_stall=1.
  - Skid buffer is cleared.
  - If no request is pending, or the response arrives this cycle: pc <= target; state FETCH.
  - If a request is pending (imem_req=1 and imem_stall=1): the address is held, the target is latched, and the state goes to DRAIN.
- DRAIN:
  - imem_req=1 with the old address until imem_stall=0.
  - The returned data is discarded, pc <= latched target, then FETCH.
  - A second redirect while in DRAIN overwrites the latched target.
- Arithmetic: pc+4 is modulo 2^32; wrap from 32'hFFFF_FFFC gives 0 with no flag.
- Reset mid-request: the request drops immediately; the memory must tolerate request withdrawal on reset.
- Opcode and func are combinational slices of the registered id_instr. With id_valid=0 they decode as R-format/func 0, which is a NOP with RegWrite to $0.

Decomposition:
- Shared package (mips_pkg):
  - fetch state enum {BOOT, FETCH, HOLD, DRAIN}.
  - NOP_WORD and PC_RESET defaults.
  - Opcode and func field bit positions.
  - Opcode constants shared with control.
- Sub-module if_skid_buf: one-entry register holding {instr, pc+4, full}, with load/clear/pop controls.

Test Plan:
- Reset release, imem_stall=0, rdata = address-indexed words: imem_addr sequence 0,1,2,3; id_instr follows one cycle later; id_pc_plus4 = 4,8,12; id_valid rises on cycle 2 after reset.
- imem_stall=1 for 3 cycles at addr 5: imem_addr holds 5; 3 bubbles (id_valid=0); fetch_busy=1; then instruction 5 with id_pc_plus4=24.
- id_stall=1 for 2 cycles while word 0x8C220004 returns: IF/ID holds its previous value, state HOLD, imem_req=0; on release id_instr=0x8C220004 with no duplicate and no lost instruction.
- redirect_valid with target 0x40 and no pending request: next imem_addr=0x10; wrong-path id_instr=NOP, id_valid=0.
- Redirect to 0x80 while imem_stall=1 at addr 7: addr 7 is held until the stall clears and its data is dropped; next fetch addr=0x20.
- Assert rst during a stalled fetch: imem_req=0 and id_valid=0 the same cycle; after release, refetch from PC_RESET.
